// File: rtl/thirty_two_bit_cla.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// thirty_two_bit_cla
//
// 32-bit two's-complement adder/subtractor, the arithmetic core of the ALU.
// Built as a two-level carry-lookahead tree:
//   - four 8-bit lookahead blocks (cla8_block), each producing its internal
//     carries as flattened sum-of-products plus a group generate/propagate,
//   - one second-level lookahead unit (cla_lookahead4) producing the block
//     carry-ins and the final carry-out straight from the group terms.
// Subtraction reuses the same tree: B is inverted and the carry-in is 1.
// The sum and signed-overflow flag are registered once (latency 1 cycle,
// one operation accepted every cycle).
//
// Ports (thirty_two_bit_cla):
//   clock   in   1  rising-edge clock
//   reset   in   1  asynchronous active-high reset, clears result and ovf
//   A       in  32  operand A, two's complement
//   B       in  32  operand B, two's complement
//   op      in   1  0 = A+B, 1 = A-B
//   ovf     out  1  signed overflow of the registered result
//   result  out 32  registered sum/difference, modulo 2^32
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cla8_block
//
// 8-bit carry-lookahead block. Every carry is written out as a flat OR of
// AND terms over g/p and the block carry-in, so no carry waits on another.
//
// Ports:
//   g    in  8  per-bit generate  (a & b)
//   p    in  8  per-bit propagate (a ^ b)
//   cin  in  1  block carry-in
//   c    out 8  carry into each bit of the block (c[0] = cin)
//   gg   out 1  group generate
//   pg   out 1  group propagate
// ---------------------------------------------------------------------------
module cla8_block (
  input  logic [7:0] g,
  input  logic [7:0] p,
  input  logic       cin,
  output logic [7:0] c,
  output logic       gg,
  output logic       pg
);

  assign c[0] = cin;

  assign c[1] = g[0]
              | (p[0] & cin);

  assign c[2] = g[1]
              | (p[1] & g[0])
              | ((&p[1:0]) & cin);

  assign c[3] = g[2]
              | (p[2] & g[1])
              | ((&p[2:1]) & g[0])
              | ((&p[2:0]) & cin);

  assign c[4] = g[3]
              | (p[3] & g[2])
              | ((&p[3:2]) & g[1])
              | ((&p[3:1]) & g[0])
              | ((&p[3:0]) & cin);

  assign c[5] = g[4]
              | (p[4] & g[3])
              | ((&p[4:3]) & g[2])
              | ((&p[4:2]) & g[1])
              | ((&p[4:1]) & g[0])
              | ((&p[4:0]) & cin);

  assign c[6] = g[5]
              | (p[5] & g[4])
              | ((&p[5:4]) & g[3])
              | ((&p[5:3]) & g[2])
              | ((&p[5:2]) & g[1])
              | ((&p[5:1]) & g[0])
              | ((&p[5:0]) & cin);

  assign c[7] = g[6]
              | (p[6] & g[5])
              | ((&p[6:5]) & g[4])
              | ((&p[6:4]) & g[3])
              | ((&p[6:3]) & g[2])
              | ((&p[6:2]) & g[1])
              | ((&p[6:1]) & g[0])
              | ((&p[6:0]) & cin);

  // Group terms exclude cin so the second level can combine blocks in parallel.
  assign gg = g[7]
            | (p[7] & g[6])
            | ((&p[7:6]) & g[5])
            | ((&p[7:5]) & g[4])
            | ((&p[7:4]) & g[3])
            | ((&p[7:3]) & g[2])
            | ((&p[7:2]) & g[1])
            | ((&p[7:1]) & g[0]);

  assign pg = &p[7:0];

endmodule

// ---------------------------------------------------------------------------
// cla_lookahead4
//
// Second-level lookahead over four 8-bit groups. Each block carry is a flat
// sum-of-products of the group generate/propagate terms and c0.
//
// Ports:
//   gg    in  4  group generate of blocks 0..3
//   pg    in  4  group propagate of blocks 0..3
//   c0    in  1  adder carry-in
//   cout  out 4  {c32, c24, c16, c8}
// ---------------------------------------------------------------------------
module cla_lookahead4 (
  input  logic [3:0] gg,
  input  logic [3:0] pg,
  input  logic       c0,
  output logic [3:0] cout
);

  // c8
  assign cout[0] = gg[0]
                 | (pg[0] & c0);

  // c16
  assign cout[1] = gg[1]
                 | (pg[1] & gg[0])
                 | ((&pg[1:0]) & c0);

  // c24
  assign cout[2] = gg[2]
                 | (pg[2] & gg[1])
                 | ((&pg[2:1]) & gg[0])
                 | ((&pg[2:0]) & c0);

  // c32
  assign cout[3] = gg[3]
                 | (pg[3] & gg[2])
                 | ((&pg[3:2]) & gg[1])
                 | ((&pg[3:1]) & gg[0])
                 | ((&pg[3:0]) & c0);

endmodule

// ---------------------------------------------------------------------------
// thirty_two_bit_cla (top)
// ---------------------------------------------------------------------------
module thirty_two_bit_cla (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        op,
  output logic        ovf,
  output logic [31:0] result
);

  logic [31:0] bop_s;       // B conditioned for add/subtract
  logic [31:0] g_s;         // per-bit generate
  logic [31:0] p_s;         // per-bit propagate
  logic [31:0] carry_s;     // carry into each bit position
  logic [3:0]  grp_g_s;     // group generate per 8-bit block
  logic [3:0]  grp_p_s;     // group propagate per 8-bit block
  logic [3:0]  blk_cin_s;   // carry-in of each block {c24, c16, c8, c0}
  logic [3:0]  look_c_s;    // lookahead outputs {c32, c24, c16, c8}
  logic        c32_s;       // carry out of bit 31
  logic [31:0] sum_s;       // combinational sum/difference
  logic        ovf_next_s;  // combinational signed overflow

  logic [31:0] result_r;
  logic        ovf_r;

  // Subtract is A + ~B + 1: invert B and feed op in as the carry-in.
  assign bop_s = B ^ {32{op}};
  assign g_s   = A & bop_s;
  assign p_s   = A ^ bop_s;

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_blk
      cla8_block u_blk (
        .g   (g_s[8*k+7 -: 8]),
        .p   (p_s[8*k+7 -: 8]),
        .cin (blk_cin_s[k]),
        .c   (carry_s[8*k+7 -: 8]),
        .gg  (grp_g_s[k]),
        .pg  (grp_p_s[k])
      );
    end
  endgenerate

  cla_lookahead4 u_look (
    .gg   (grp_g_s),
    .pg   (grp_p_s),
    .c0   (op),
    .cout (look_c_s)
  );

  assign blk_cin_s = {look_c_s[2:0], op};
  assign c32_s     = look_c_s[3];

  assign sum_s = p_s ^ carry_s;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf_next_s = carry_s[31] ^ c32_s;

  // Output registers: capture sum and overflow each edge, cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_r <= 32'h0000_0000;
      ovf_r    <= 1'b0;
    end else begin
      result_r <= sum_s;
      ovf_r    <= ovf_next_s;
    end
  end

  assign result = result_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_thirty_two_bit_cla.sv
`timescale 1ns/1ps
// Self-checking bench for thirty_two_bit_cla: directed vectors with
// hand-computed results, then back-to-back random vectors against a
// behavioural reference, with a reset pulse inserted mid-stream.
module tb_thirty_two_bit_cla;

  logic        clock;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        op;
  logic        ovf;
  logic [31:0] result;

  int n_checks;
  int n_fail;

  thirty_two_bit_cla dut (
    .clock  (clock),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .op     (op),
    .ovf    (ovf),
    .result (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts and reports mismatches.
  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one operation, let one edge pass, then check the registered output.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic o, input logic [31:0] exp_res, input logic exp_ovf);
    A  = a;
    B  = b;
    op = o;
    @(posedge clock);
    #1;
    check_value({tag, ".result"}, result, exp_res);
    check_value({tag, ".ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        ro;
    logic [31:0] rexp;
    logic        rovf;

    n_checks = 0;
    n_fail   = 0;

    // Reset applied before any clock edge must clear the outputs at once.
    reset = 1'b1;
    A     = 32'd5;
    B     = 32'd3;
    op    = 1'b0;
    #2;
    check_value("reset_noclk.result", result, 32'h0000_0000);
    check_value("reset_noclk.ovf", {31'd0, ovf}, 32'd0);
    @(posedge clock);
    #1;
    check_value("reset_held.result", result, 32'h0000_0000);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_value("first_edge.result", result, 32'h0000_0008);
    check_value("first_edge.ovf", {31'd0, ovf}, 32'd0);

    // Directed vectors, one per cycle (back-to-back).
    run_op("sub_neg",      32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_op("wrap_all",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0);
    run_op("cross_blocks", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0);
    run_op("cross_16",     32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0);
    run_op("pos_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1);
    run_op("neg_ovf",      32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1);
    run_op("zero_m_min",   32'h0000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1);
    run_op("min_m_min",    32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0);
    run_op("min_p_min",    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
    run_op("add_small",    32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0);
    run_op("sub_small",    32'h0000_0001, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_op("add_mixed",    32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
    run_op("sub_mixed",    32'h1234_5678, 32'h1111_1111, 1'b1, 32'h0123_4567, 1'b0);
    run_op("neg1_p_neg1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0);
    run_op("neg1_m_neg1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);
    run_op("max_m_neg1",   32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);

    // Random back-to-back vectors against a behavioural reference.
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        // Mid-stream reset pulse, asserted between edges.
        reset = 1'b1;
        #1;
        check_value("mid_reset.result", result, 32'h0000_0000);
        check_value("mid_reset.ovf", {31'd0, ovf}, 32'd0);
        @(posedge clock);
        #1;
        check_value("mid_reset_held.result", result, 32'h0000_0000);
        reset = 1'b0;
      end
      ra = $urandom;
      rb = $urandom;
      ro = 1'($urandom_range(0, 1));
      if (ro) begin
        rexp = ra - rb;
        rovf = (ra[31] != rb[31]) && (rexp[31] != ra[31]);
      end else begin
        rexp = ra + rb;
        rovf = (ra[31] == rb[31]) && (rexp[31] != ra[31]);
      end
      run_op("random", ra, rb, ro, rexp, rovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/thirty_two_bit_cla.md
Name: thirty_two_bit_cla

Overview:
32-bit two's-complement adder/subtractor built on a hierarchical carry-lookahead (CLA) structure. It is the arithmetic core of the ALU. It computes A+B or A-B and flags signed overflow. Outputs are registered on one clock, with asynchronous active-high reset.

Parameters:
- None. Width is fixed at 32 bits.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- A  input  32  operand A, two's complement
- B  input  32  operand B, two's complement
- op  input  1  0 = add (A+B), 1 = subtract (A-B)
- ovf  output  1  signed overflow of the registered result
- result  output  32  registered sum or difference, modulo 2^32

Behaviour:
- Operand conditioning:
  - Bop = B XOR {32{op}}.
  - Carry-in c0 = op, so subtract is A + ~B + 1.
- CLA structure:
  - Per bit: g_i = A_i & Bop_i; p_i = A_i ^ Bop_i; sum_i = p_i ^ c_i.
  - Four 8-bit CLA blocks. Inside each block, every carry is a flattened sum-of-products of g/p and the block carry-in. No ripple inside a block.
  - Each block exports group generate G = g7 | p7g6 | ... | p7..p1g0 and group propagate P = p7&...&p0.
  - A second-level lookahead unit forms the block carry-ins from G/P and c0: c8 = G0|P0c0, c16 = G1|P1G0|P1P0c0, c24 similarly, and c32. No ripple between blocks.
  - The same structure is used for add and subtract. No separate subtractor.
- Overflow:
  - ovf_next = (A[31] == Bop[31]) & (sum[31] != A[31]), equivalently c31 XOR c32.
  - Unsigned carry-out c32 is not exported.
- Timing:
  - Combinational path A/B/op -> sum/ovf_next is registered on each rising clock edge.
  - Latency is 1 cycle. A new operation is accepted every cycle. No handshake; inputs are sampled every edge.
- Reset:
  - While reset=1, result=32'h0 and ovf=0, asynchronously and immediately, regardless of clock.
  - A reset asserted mid-operation discards the in-flight result.
  - After deassertion, the first rising edge captures the current inputs.
- Boundary rules:
  - Wrap-around is modulo 2^32 with no saturation.
  - 0 - 0x80000000 = 0x80000000 with ovf=1.
  - 0x80000000 - 0x80000000 = 0 with ovf=0.
  - The X-A path is fully combinational; no internal state besides the two output registers.

Test Plan:
- Reset: assert reset with A=5, B=3 -> result=0, ovf=0 with no clock edge. Deassert, one edge -> result=0x00000008, ovf=0.
- Subtract to negative: A=0, B=1, op=1 -> result=0xFFFFFFFF, ovf=0 one cycle later.
- Full carry chain: A=0xFFFFFFFF, B=1, op=0 -> result=0x00000000, ovf=0. A=0x00FFFFFF, B=1, op=0 -> result=0x01000000 (carry crosses every block boundary).
- Positive overflow: A=0x7FFFFFFF, B=1, op=0 -> result=0x80000000, ovf=1. Negative overflow: A=0x80000000, B=1, op=1 -> result=0x7FFFFFFF, ovf=1.
- Edge subtract: A=0, B=0x80000000, op=1 -> result=0x80000000, ovf=1. A=B=0x80000000, op=1 -> result=0, ovf=0.
- Back-to-back and random: change inputs every cycle. Each output equals the reference A±B and the overflow formula from the previous edge. At least 10k random vectors, plus a reset pulse inserted mid-stream that clears the outputs immediately.
